seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 124 ++++++++++++
 tb/tb_seq_multiplier.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module   : seq_multiplier
// Summary  : Sequential shift-and-add unsigned multiplier with valid/ready
//            handshakes, consuming BITS_PER_CYCLE multiplier bits per cycle.
//            Optional macro SEQ_MULT_EARLY_TERM_EN ends BUSY once b runs out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier #(
    parameter int WIDTH_A        = 8,
    parameter int WIDTH_B        = 9,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] mult_out
);

    localparam int PROD_W = WIDTH_A + WIDTH_B;
    localparam int N      = WIDTH_B / BITS_PER_CYCLE;
    localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [STEP_W-1:0] c_last_step = STEP_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      w_accept;
    logic                      w_last;
    logic [PROD_W-1:0]         r_a_sh;
    logic [WIDTH_B-1:0]        r_b;
    logic [WIDTH_B-1:0]        w_b_next;
    logic [PROD_W-1:0]         r_acc;
    logic [STEP_W-1:0]         r_step;
    logic [BITS_PER_CYCLE-1:0] w_b_low;
    logic [PROD_W-1:0]         w_pp;

    // r_a_sh carries a pre-shifted by BITS_PER_CYCLE*step, so no barrel shifter is needed
    assign w_b_low  = r_b[BITS_PER_CYCLE-1:0];
    assign w_pp     = r_a_sh * {{(PROD_W-BITS_PER_CYCLE){1'b0}}, w_b_low};
    assign w_b_next = r_b >> BITS_PER_CYCLE;

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign w_last = (w_b_next == '0) || (r_step == c_last_step);
`else
    assign w_last = (r_step == c_last_step);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_a_sh <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_step <= '0;
        end else if (w_accept) begin
            r_a_sh <= {{WIDTH_B{1'b0}}, a};
            r_b    <= b;
            r_acc  <= '0;
            r_step <= '0;
        end else if (r_state == BUSY) begin
            r_acc  <= r_acc + w_pp;
            r_b    <= w_b_next;
            r_a_sh <= r_a_sh << BITS_PER_CYCLE;
            r_step <= r_step + STEP_W'(1);
        end
    end

    assign mult_out = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: runs one BITS_PER_CYCLE=1 and one BITS_PER_CYCLE=3
// instance side by side on shared inputs against hand-computed products.
`default_nettype none

module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a;
    logic [8:0]  b;
    logic        in_ready1, out_valid1;
    logic        in_ready3, out_valid3;
    logic [16:0] mult1, mult3;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH_A(8), .WIDTH_B(9), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .mult_out(mult1)
    );

    seq_multiplier #(.WIDTH_A(8), .WIDTH_B(9), .BITS_PER_CYCLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready3),
        .a(a), .b(b), .out_valid(out_valid3), .out_ready(out_ready), .mult_out(mult3)
    );

    typedef struct {
        logic [7:0]  va;
        logic [8:0]  vb;
        logic [16:0] prod;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Latency seen by the consumer, counted in edges after the acceptance edge
    function automatic int exp_lat(input logic [8:0] bv, input int bpc);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int m;
        m = -1;
        for (int i = 0; i < 9; i++) if (bv[i]) m = i;
        if (m < 0) return 1;
        return (m + bpc) / bpc;
`else
        return 9 / bpc;
`endif
    endfunction

    task automatic run_op(input logic [7:0] va, input logic [8:0] vb,
                          input logic [16:0] prod, input string name);
        int lat1, lat3;
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
        chk({name, "_in_ready1"}, 32'(in_ready1), 32'd1);
        chk({name, "_in_ready3"}, 32'(in_ready3), 32'd1);
        step_clk();
        in_valid = 1'b0;
        chk({name, "_busy_in_ready1"}, 32'(in_ready1), 32'd0);
        lat1 = -1;
        lat3 = -1;
        for (int k = 1; k <= 20 && (lat1 < 0 || lat3 < 0); k++) begin
            step_clk();
            if (out_valid1 && lat1 < 0) lat1 = k;
            if (out_valid3 && lat3 < 0) lat3 = k;
        end
        chk({name, "_lat1"}, 32'(lat1), 32'(exp_lat(vb, 1)));
        chk({name, "_lat3"}, 32'(lat3), 32'(exp_lat(vb, 3)));
        chk({name, "_mult1"}, 32'(mult1), 32'(prod));
        chk({name, "_mult3"}, 32'(mult3), 32'(prod));
        out_ready = 1'b1;
        step_clk();
        out_ready = 1'b0;
        chk({name, "_idle_in_ready1"}, 32'(in_ready1), 32'd1);
        chk({name, "_idle_out_valid1"}, 32'(out_valid1), 32'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0;
        repeat (3) step_clk();
        chk("reset_in_ready", 32'(in_ready1), 32'd1);
        chk("reset_out_valid", 32'(out_valid1), 32'd0);
        chk("reset_mult", 32'(mult1), 32'd0);
        rst = 1'b1;
        step_clk();

        vecs[0] = '{8'd255, 9'd511, 17'd130305};
        vecs[1] = '{8'd200, 9'd300, 17'd60000};
        vecs[2] = '{8'd13,  9'd3,   17'd39};
        vecs[3] = '{8'd0,   9'd123, 17'd0};
        vecs[4] = '{8'd77,  9'd0,   17'd0};
        vecs[5] = '{8'd10,  9'd3,   17'd30};
        vecs[6] = '{8'd1,   9'd256, 17'd256};
        vecs[7] = '{8'd128, 9'd257, 17'd32896};
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].prod, $sformatf("vec%0d", i));
        end

        // Back-pressure: result held while out_ready=0; in_valid in BUSY/DONE is ignored
        a = 8'd13; b = 9'd3; in_valid = 1'b1; out_ready = 1'b0;
        step_clk();
        a = 8'd99; b = 9'd5;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step_clk();
            seen = out_valid1;
        end
        in_valid = 1'b0;
        chk("hold_reached_done", 32'(seen), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_mult", k), 32'(mult1), 32'd39);
            chk($sformatf("hold%0d_out_valid", k), 32'(out_valid1), 32'd1);
            chk($sformatf("hold%0d_in_ready", k), 32'(in_ready1), 32'd0);
            step_clk();
        end
        chk("hold_mult3", 32'(mult3), 32'd39);
        out_ready = 1'b1;
        step_clk();
        out_ready = 1'b0;
        chk("hold_release_in_ready", 32'(in_ready1), 32'd1);
        chk("hold_release_out_valid", 32'(out_valid1), 32'd0);

        // clr in the 4th BUSY cycle aborts with nothing left behind
        a = 8'd7; b = 9'd100; in_valid = 1'b1;
        step_clk();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step_clk();
            chk($sformatf("clr_busy%0d_out_valid", k), 32'(out_valid1), 32'd0);
        end
        clr = 1'b1;
        step_clk();
        clr = 1'b0;
        chk("clr_in_ready", 32'(in_ready1), 32'd1);
        chk("clr_out_valid", 32'(out_valid1), 32'd0);
        chk("clr_mult", 32'(mult1), 32'd0);
        for (int k = 0; k < 10; k++) begin
            step_clk();
            chk($sformatf("clr_after%0d_out_valid", k), 32'(out_valid1), 32'd0);
        end
        run_op(8'd2, 9'd3, 17'd6, "after_clr");

        // clr beats in_valid in IDLE
        a = 8'd5; b = 9'd5; in_valid = 1'b1; clr = 1'b1;
        step_clk();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_prio_in_ready", 32'(in_ready1), 32'd1);
        chk("clr_prio_mult", 32'(mult1), 32'd0);

        // rst while in DONE
        a = 8'd9; b = 9'd9; in_valid = 1'b1; out_ready = 1'b0;
        step_clk();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step_clk();
            seen = out_valid1;
        end
        chk("rst_reached_done", 32'(seen), 32'd1);
        chk("rst_done_mult", 32'(mult1), 32'd81);
        rst = 1'b0;
        step_clk();
        rst = 1'b1;
        chk("rst_in_ready1", 32'(in_ready1), 32'd1);
        chk("rst_out_valid1", 32'(out_valid1), 32'd0);
        chk("rst_mult1", 32'(mult1), 32'd0);
        chk("rst_in_ready3", 32'(in_ready3), 32'd1);
        chk("rst_mult3", 32'(mult3), 32'd0);
        step_clk();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
